riscv_run_controller: RTL and testbench

- Synthesizable run/halt controller for the RISC-V core; replaces free-running simulation with a bounded, self-checking run.
- Sequences core reset, gates core execution, counts cycles and retired instructions, and ends the run on one of three events: a tohost store, a PC self-loop, or a cycle timeout.
- Sits between the top-level bench/board clock and RISCV_32. It snoops the data-memory write port and the PC.

---
 rtl/riscv_run_controller.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_run_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_controller.sv
// Run/halt controller: sequences core reset, gates core_en, counts RUN cycles/retires and stops on tohost, PC self-loop or timeout.
// Termination flags register one cycle after the deciding RUN cycle; no backpressure, start is only honoured in IDLE/DONE.
module riscv_run_controller #(
    parameter int                XLEN         = 32,
    parameter int                CNT_W        = 32,
    parameter int                RESET_CYCLES = 4,
    parameter int                MAX_CYCLES   = 100000,
    parameter int                STALL_LIMIT  = 8,
    parameter logic [XLEN-1:0]   TOHOST_ADDR  = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic [XLEN-1:0]   pc,
    input  logic              retire,
    input  logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              hang,
    output logic              timeout,
    output logic [XLEN-1:0]   exit_code,
    output logic [XLEN-1:0]   halt_pc,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST_HOLD = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]   CYC_MAX   = CNT_W'(MAX_CYCLES);
    localparam logic [XLEN-1:0]    WDATA_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [XLEN-1:0]    prev_pc_q, prev_pc_d;
    logic               first_q, first_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               hang_q, hang_d;
    logic               timeout_q, timeout_d;
    logic [XLEN-1:0]    exit_q, exit_d;
    logic [XLEN-1:0]    halt_pc_q, halt_pc_d;

    logic [CNT_W-1:0]   cycle_inc;
    logic [CNT_W-1:0]   instr_inc;
    logic [STALL_W-1:0] stall_nxt;
    logic               tohost_hit;
    logic               hang_hit;
    logic               timeout_hit;

    // Saturating increments; in practice the run ends long before they clip.
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
    assign instr_inc = (instr_q == '1) ? instr_q : instr_q + 1'b1;

    // The first RUN cycle only primes prev_pc, so a stale prev_pc can never match.
    assign stall_nxt = (!first_q && (pc == prev_pc_q))
                     ? ((stall_q == '1) ? stall_q : stall_q + 1'b1)
                     : '0;

    assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR);
    assign hang_hit    = (stall_nxt == STALL_HIT);
    assign timeout_hit = (cycle_inc == CYC_MAX);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        stall_d   = stall_q;
        prev_pc_d = prev_pc_q;
        first_d   = first_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        hang_d    = hang_q;
        timeout_d = timeout_q;
        exit_d    = exit_q;
        halt_pc_d = halt_pc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RST_HOLD;
                    hold_d    = '0;
                    cycle_d   = '0;
                    instr_d   = '0;
                    stall_d   = '0;
                    prev_pc_d = '0;
                    first_d   = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    hang_d    = 1'b0;
                    timeout_d = 1'b0;
                    exit_d    = '0;
                    halt_pc_d = '0;
                end
            end

            S_RST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    first_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            S_RUN: begin
                cycle_d   = cycle_inc;
                stall_d   = stall_nxt;
                prev_pc_d = pc;
                first_d   = 1'b0;
                if (retire) begin
                    instr_d = instr_inc;
                end

                // The deciding cycle is still counted above; only one flag is raised.
                if (tohost_hit) begin
                    state_d   = S_DONE;
                    halt_pc_d = pc;
                    exit_d    = dmem_wdata >> 1;
                    if (dmem_wdata == WDATA_ONE) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end else if (hang_hit) begin
                    state_d   = S_DONE;
                    halt_pc_d = pc;
                    hang_d    = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_DONE;
                    halt_pc_d = pc;
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            cycle_q   <= '0;
            instr_q   <= '0;
            stall_q   <= '0;
            prev_pc_q <= '0;
            first_q   <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            hang_q    <= 1'b0;
            timeout_q <= 1'b0;
            exit_q    <= '0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            stall_q   <= stall_d;
            prev_pc_q <= prev_pc_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            hang_q    <= hang_d;
            timeout_q <= timeout_d;
            exit_q    <= exit_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    // Core controls decode straight from the state register so reset reaches the core immediately.
    assign core_rst_n  = (state_q == S_RUN) || (state_q == S_DONE);
    assign core_en     = (state_q == S_RUN);
    assign busy        = (state_q == S_RST_HOLD) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign hang        = hang_q;
    assign timeout     = timeout_q;
    assign exit_code   = exit_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Bench for riscv_run_controller: directed scenario table, reset/restart sequences and random runs against a scan-based model.
module tb_riscv_run_controller;

    localparam int          RC     = 4;
    localparam int          MC     = 100;
    localparam int          SL     = 8;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam int          SLEN   = MC + 12;

    logic        clk = 1'b0;
    logic        rst_n, start, retire, dmem_we;
    logic [31:0] pc, dmem_addr, dmem_wdata;
    logic        core_rst_n, core_en, busy, done, pass, fail, hang, timeout;
    logic [31:0] exit_code, halt_pc, cycle_count, instr_count;

    always #5 clk = ~clk;

    riscv_run_controller #(
        .XLEN(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MC),
        .STALL_LIMIT(SL), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .core_rst_n(core_rst_n), .core_en(core_en),
        .pc(pc), .retire(retire), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .hang(hang), .timeout(timeout), .exit_code(exit_code),
        .halt_pc(halt_pc), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    typedef struct {
        int          cyc;
        int          instr;
        bit          p, f, h, t;
        logic [31:0] ec;
        logic [31:0] hpc;
    } res_t;

    typedef struct {
        int          st_cyc;
        logic [31:0] st_addr;
        logic [31:0] st_wd;
        int          freeze;
        res_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] s_pc   [0:SLEN-1];
    bit          s_ret  [0:SLEN-1];
    bit          s_we   [0:SLEN-1];
    logic [31:0] s_addr [0:SLEN-1];
    logic [31:0] s_wd   [0:SLEN-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scan the per-cycle stimulus: first cycle where a store to tohost, a run of SL equal pcs, or the budget ends the run.
    function automatic res_t model();
        res_t r;
        int   rl = 0;
        int   ni = 0;
        r = '{default: 0};
        for (int k = 1; k <= MC; k++) begin
            rl = (k > 1 && s_pc[k] == s_pc[k-1]) ? rl + 1 : 1;
            if (s_ret[k]) ni++;
            if (s_we[k] && s_addr[k] == TOHOST) begin
                r.p  = (s_wd[k] == 32'd1);
                r.f  = !r.p;
                r.ec = s_wd[k] >> 1;
            end else if (rl >= SL) begin
                r.h = 1'b1;
            end else if (k == MC) begin
                r.t = 1'b1;
            end
            if (r.p || r.f || r.h || r.t) begin
                r.cyc   = k;
                r.instr = ni;
                r.hpc   = s_pc[k];
                return r;
            end
        end
        return r;
    endfunction

    task automatic run_stim(input string tag, input res_t exp, input bit poke_start);
        int hold;
        int k;
        bit ended;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " clr cyc"}, cycle_count, 32'd0);
        chk({tag, " clr instr"}, instr_count, 32'd0);
        chk({tag, " clr flags"}, 32'({done, pass, fail, hang, timeout}), 32'd0);
        chk({tag, " clr ec/hpc"}, exit_code | halt_pc, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        hold = 0;
        while (!core_rst_n && hold < 20) begin
            hold++;
            start = poke_start ? 1'(($urandom % 2)) : 1'b0;
            step();
        end
        start = 1'b0;
        chk({tag, " rst hold"}, hold, RC);
        chk({tag, " core_en run"}, 32'(core_en), 32'd1);
        k = 0;
        ended = 1'b0;
        while (!ended && k < MC + 10) begin
            k++;
            pc         = s_pc[k];
            retire     = s_ret[k];
            dmem_we    = s_we[k];
            dmem_addr  = s_addr[k];
            dmem_wdata = s_wd[k];
            start      = poke_start ? 1'(($urandom % 2)) : 1'b0;
            step();
            if (done) ended = 1'b1;
        end
        start   = 1'b0;
        dmem_we = 1'b0;
        retire  = 1'b0;
        chk({tag, " ended"}, 32'(ended), 32'd1);
        chk({tag, " end cycle"}, k, exp.cyc);
        chk({tag, " cycle_count"}, cycle_count, exp.cyc);
        chk({tag, " instr_count"}, instr_count, exp.instr);
        chk({tag, " flags pfht"}, 32'({pass, fail, hang, timeout}), 32'({exp.p, exp.f, exp.h, exp.t}));
        chk({tag, " exit_code"}, exit_code, exp.ec);
        chk({tag, " halt_pc"}, halt_pc, exp.hpc);
        chk({tag, " frozen"}, 32'({core_en, core_rst_n, busy}), 32'b010);
        // Activity in DONE must not disturb anything.
        retire     = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = TOHOST;
        dmem_wdata = 32'd1;
        for (int i = 0; i < 3; i++) begin
            pc = pc + 32'd4;
            step();
        end
        retire  = 1'b0;
        dmem_we = 1'b0;
        chk({tag, " hold cyc"}, cycle_count, exp.cyc);
        chk({tag, " hold instr"}, instr_count, exp.instr);
        chk({tag, " hold flags"}, 32'({done, pass, fail, hang, timeout}), 32'({1'b1, exp.p, exp.f, exp.h, exp.t}));
        chk({tag, " hold hpc"}, halt_pc, exp.hpc);
    endtask

    task automatic fill_table(input vec_t v);
        for (int k = 0; k < SLEN; k++) begin
            s_pc[k]   = (v.freeze != 0 && k >= v.freeze) ? 32'(32'h10 + 4 * v.freeze) : 32'(32'h10 + 4 * k);
            s_ret[k]  = 1'b1;
            s_we[k]   = (v.st_cyc != 0 && k == v.st_cyc);
            s_addr[k] = s_we[k] ? v.st_addr : 32'd0;
            s_wd[k]   = v.st_wd;
        end
    endtask

    task automatic fill_random();
        logic [31:0] pcv;
        int          fr;
        int          sc;
        pcv = $urandom & 32'hFFFF_FFFC;
        fr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 90)) : 0;
        sc  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, MC + 5)) : 0;
        for (int k = 0; k < SLEN; k++) begin
            if (k > 0 && !(fr != 0 && k >= fr) && $urandom_range(0, 5) != 0)
                pcv = pcv + 32'(4 * $urandom_range(1, 4));
            s_pc[k]  = pcv;
            s_ret[k] = 1'($urandom % 2);
            if (k == sc) begin
                s_we[k]   = 1'b1;
                s_addr[k] = TOHOST;
                s_wd[k]   = 32'($urandom_range(0, 3));
            end else begin
                s_we[k]   = ($urandom_range(0, 7) == 0);
                s_addr[k] = $urandom | 32'd1;
                s_wd[k]   = 32'd1;
            end
        end
    endtask

    vec_t tbl [0:8];

    initial begin
        int w;
        tbl[0] = '{20,  TOHOST,       32'd1, 0,  '{20,  20,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h60}};
        tbl[1] = '{10,  TOHOST,       32'd7, 0,  '{10,  10,  1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h38}};
        tbl[2] = '{0,   TOHOST,       32'd0, 12, '{19,  19,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h40}};
        tbl[3] = '{0,   TOHOST,       32'd0, 0,  '{100, 100, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1A0}};
        tbl[4] = '{100, TOHOST,       32'd1, 0,  '{100, 100, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1A0}};
        tbl[5] = '{0,   TOHOST,       32'd0, 1,  '{8,   8,   1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h14}};
        tbl[6] = '{19,  TOHOST,       32'd5, 12, '{19,  19,  1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'h40}};
        tbl[7] = '{5,   32'h0000_1004, 32'd1, 0, '{100, 100, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1A0}};
        tbl[8] = '{1,   TOHOST,       32'd0, 0,  '{1,   1,   1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h14}};

        rst_n = 1'b0; start = 1'b0; retire = 1'b0; dmem_we = 1'b0;
        pc = 32'd0; dmem_addr = 32'd0; dmem_wdata = 32'd0;
        #12;
        chk("reset core", 32'({core_rst_n, core_en, busy, done}), 32'd0);
        chk("reset flags", 32'({pass, fail, hang, timeout}), 32'd0);
        chk("reset regs", exit_code | halt_pc | cycle_count | instr_count, 32'd0);
        rst_n = 1'b1;
        step();
        retire = 1'b1;
        step();
        chk("idle no count", instr_count, 32'd0);
        chk("idle state", 32'({core_rst_n, busy, done}), 32'd0);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        step();
        start = 1'b0;
        w = 0;
        while (!core_en && w < 20) begin
            w++;
            step();
        end
        for (int k = 1; k <= 49; k++) begin
            pc = 32'(32'h100 + 4 * k);
            step();
        end
        chk("mid cyc49", cycle_count, 32'd49);
        chk("mid instr49", instr_count, 32'd49);
        #2 rst_n = 1'b0;
        #1;
        chk("async core", 32'({core_rst_n, core_en, busy, done}), 32'd0);
        chk("async cnts", cycle_count | instr_count, 32'd0);
        step();
        rst_n = 1'b1;
        retire = 1'b0;
        step();
        step();
        chk("post rst idle", 32'({core_rst_n, core_en, busy, done}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            fill_table(tbl[i]);
            run_stim($sformatf("tbl%0d", i), tbl[i].exp, (i == 0));
        end

        for (int i = 0; i < 40; i++) begin
            fill_random();
            run_stim($sformatf("rnd%0d", i), model(), 1'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
